spi_slave: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0) and the far end of spi_interface; lets an FPGA-side peripheral answer our own SPI master.
- Oversamples scl, cs and mosi in the local clk domain.
- Deserialises mosi into bytes and serialises a byte stream onto miso.
- Supports single-byte frames and continuous back-to-back frames while cs stays low.

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants, types and bit-order helpers for the SPI slave.
package spi_pkg;

  // Mode 0: scl idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [BYTE_W-1:0] TX_IDLE_DEFAULT = 8'h00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bit that goes on the wire first for a freshly loaded byte.
  function automatic logic tx_first_bit(input logic [BYTE_W-1:0] b, input logic lsb_first);
    tx_first_bit = lsb_first ? b[0] : b[BYTE_W-1];
  endfunction

  // Advance the tx register by one bit in the selected order.
  function automatic logic [BYTE_W-1:0] tx_shift(input logic [BYTE_W-1:0] b, input logic lsb_first);
    tx_shift = lsb_first ? {1'b0, b[BYTE_W-1:1]} : {b[BYTE_W-2:0], 1'b0};
  endfunction

  // Insert a received bit into the rx register in the selected order.
  function automatic logic [BYTE_W-1:0] rx_insert(input logic [BYTE_W-1:0] b, input logic bit_in,
                                                  input logic lsb_first);
    rx_insert = lsb_first ? {bit_in, b[BYTE_W-1:1]} : {b[BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with rise/fall pulse outputs for one async input.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  // Reset to 0 so a line already low at release never looks like a falling edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled inputs, byte deserialiser and byte serialiser
// with a one-deep tx holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] TX_IDLE    = TX_IDLE_DEFAULT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              msb_lsb,
  input  logic              scl,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  // Sample edge follows from the mode constants; shift on the opposite edge.
  localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_s;
  logic sample_s, shift_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .arst(arst), .d(scl), .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .arst(arst), .d(cs), .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .arst(arst), .d(mosi), .level(mosi_s), .rise(), .fall()
  );

  assign sample_s = SAMPLE_ON_RISE ? scl_rise_s : scl_fall_s;
  assign shift_s  = SAMPLE_ON_RISE ? scl_fall_s : scl_rise_s;

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [BYTE_W-1:0] rx_sh_r, rx_sh_nxt;
  logic [BYTE_W-1:0] tx_sh_r, tx_sh_nxt;
  logic [BYTE_W-1:0] hold_r, hold_nxt;
  logic              hold_full_r, hold_full_nxt;
  logic [BYTE_W-1:0] rx_byte_r, rx_byte_nxt;
  logic              rx_valid_r, rx_valid_nxt;
  logic              underrun_r, underrun_nxt;
  logic              frame_err_r, frame_err_nxt;
  logic              miso_r, miso_nxt;
  logic              miso_oe_r, miso_oe_nxt;
  logic              busy_r, busy_nxt;
  logic              tx_ready_r, tx_ready_nxt;

  logic              accept_s;
  logic [BYTE_W-1:0] load_val_s;
  logic [BYTE_W-1:0] rx_asm_s;
  logic [BYTE_W-1:0] tx_shifted_s;

  assign accept_s     = tx_valid & tx_ready_r;
  assign load_val_s   = hold_full_r ? hold_r : TX_IDLE;
  assign rx_asm_s     = rx_insert(rx_sh_r, mosi_s, msb_lsb);
  assign tx_shifted_s = tx_shift(tx_sh_r, msb_lsb);

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rx_sh_r     <= {BYTE_W{1'b0}};
      tx_sh_r     <= {BYTE_W{1'b0}};
      hold_r      <= {BYTE_W{1'b0}};
      hold_full_r <= 1'b0;
      rx_byte_r   <= {BYTE_W{1'b0}};
      rx_valid_r  <= 1'b0;
      underrun_r  <= 1'b0;
      frame_err_r <= 1'b0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
      tx_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      rx_sh_r     <= rx_sh_nxt;
      tx_sh_r     <= tx_sh_nxt;
      hold_r      <= hold_nxt;
      hold_full_r <= hold_full_nxt;
      rx_byte_r   <= rx_byte_nxt;
      rx_valid_r  <= rx_valid_nxt;
      underrun_r  <= underrun_nxt;
      frame_err_r <= frame_err_nxt;
      miso_r      <= miso_nxt;
      miso_oe_r   <= miso_oe_nxt;
      busy_r      <= busy_nxt;
      tx_ready_r  <= tx_ready_nxt;
    end
  end

  // Next-state and datapath logic. cs rising takes priority over any scl edge.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    rx_sh_nxt     = rx_sh_r;
    tx_sh_nxt     = tx_sh_r;
    hold_nxt      = hold_r;
    hold_full_nxt = hold_full_r;
    rx_byte_nxt   = rx_byte_r;
    rx_valid_nxt  = 1'b0;
    underrun_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    miso_nxt      = miso_r;
    miso_oe_nxt   = miso_oe_r;
    busy_nxt      = busy_r;

    case (state_r)
      IDLE: begin
        cnt_nxt     = {CNT_W{1'b0}};
        miso_nxt    = 1'b0;
        miso_oe_nxt = 1'b0;
        busy_nxt    = 1'b0;
        if (cs_fall_s) begin
          // Consume the held byte (old contents) or fall back to the idle pattern.
          tx_sh_nxt     = load_val_s;
          underrun_nxt  = ~hold_full_r;
          hold_full_nxt = 1'b0;
          miso_nxt      = tx_first_bit(load_val_s, msb_lsb);
          miso_oe_nxt   = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = ACTIVE;
        end else begin
          state_nxt = IDLE;
        end
      end

      ACTIVE: begin
        if (cs_rise_s) begin
          // Partial rx byte and unsent tx byte are dropped; holding register kept.
          frame_err_nxt = (cnt_r != {CNT_W{1'b0}});
          cnt_nxt       = {CNT_W{1'b0}};
          miso_nxt      = 1'b0;
          miso_oe_nxt   = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else if (sample_s) begin
          rx_sh_nxt = rx_asm_s;
          cnt_nxt   = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            rx_byte_nxt  = rx_asm_s;
            rx_valid_nxt = 1'b1;
          end else begin
            rx_valid_nxt = 1'b0;
          end
        end else if (shift_s) begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            tx_sh_nxt = tx_shifted_s;
            miso_nxt  = tx_first_bit(tx_shifted_s, msb_lsb);
          end else begin
            // Byte boundary: reload exactly as on frame start.
            tx_sh_nxt     = load_val_s;
            underrun_nxt  = ~hold_full_r;
            hold_full_nxt = 1'b0;
            miso_nxt      = tx_first_bit(load_val_s, msb_lsb);
          end
        end else begin
          state_nxt = ACTIVE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = {CNT_W{1'b0}};
        miso_nxt    = 1'b0;
        miso_oe_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
    endcase

    // A byte accepted in the same cycle as a consume survives the consume.
    if (accept_s) begin
      hold_nxt      = tx_byte;
      hold_full_nxt = 1'b1;
    end else begin
      hold_nxt = hold_nxt;
    end

    tx_ready_nxt = ~hold_full_nxt;
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign tx_ready    = tx_ready_r;
  assign rx_byte     = rx_byte_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = underrun_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

  // The synchronised levels feed only the edge detectors.
  logic unused_lvl_s;
  assign unused_lvl_s = scl_lvl_s ^ cs_lvl_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: a behavioural mode-0 master plus pulse monitors.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       msb_lsb = 1'b0;
  logic       scl = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid, tx_underrun, frame_err, busy;

  int tests = 0;
  int fails = 0;

  // Monitor counters, written only by the monitor process.
  int         rx_cnt = 0;
  int         ur_cnt = 0;
  int         fe_cnt = 0;
  int         rdy_rise = 0;
  logic       rdy_prev = 1'b1;
  logic [7:0] rx_q[$];

  spi_slave #(.SYNC_STAGES(2), .TX_IDLE(8'h00)) dut (
    .clk(clk), .arst(arst), .msb_lsb(msb_lsb), .scl(scl), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt = rx_cnt + 1;
      rx_q.push_back(rx_byte);
    end
    if (tx_underrun) ur_cnt = ur_cnt + 1;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (tx_ready && !rdy_prev) rdy_rise = rdy_rise + 1;
    rdy_prev = tx_ready;
  end

  // Push one byte through the tx handshake, bounded wait for tx_ready.
  task automatic load_tx(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (!tx_ready) begin
      fails++;
      $display("FAIL load_tx_timeout: tx_ready=%0b required 1", tx_ready);
    end else begin
      tx_byte  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  // Clock nbits mode-0 bits; optionally raise cs together with the final scl fall.
  task automatic xfer_byte(input logic [7:0] tx_b, input logic lsb, input int nbits,
                           input logic end_frame, output logic [7:0] rx_b);
    rx_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = lsb ? tx_b[i] : tx_b[7-i];
      repeat (8) @(negedge clk);
      rx_b = lsb ? {miso, rx_b[7:1]} : {rx_b[6:0], miso};
      scl = 1'b1;
      repeat (8) @(negedge clk);
      scl = 1'b0;
      if (end_frame && i == nbits - 1) cs = 1'b1;
    end
    if (end_frame) repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL rst_miso: got %0b want 0", miso); end
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %0b want 0", miso_oe); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b want 1", tx_ready); end
    tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL rst_rx_byte: got %h want 00", rx_byte); end
    tests++; if ({rx_valid, tx_underrun, frame_err} !== 3'b000) begin
      fails++; $display("FAIL rst_pulses: got %b want 000", {rx_valid, tx_underrun, frame_err}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
    arst = 1'b0;
    repeat (8) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single_msb();
    logic [7:0] r;
    int rx0 = rx_cnt, ur0 = ur_cnt, fe0 = fe_cnt;
    msb_lsb = 1'b0;
    load_tx(8'h3C);
    @(negedge clk); cs = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL latency_early_oe: got %0b want 0", miso_oe); end
    @(negedge clk);
    tests++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL latency_oe: got %0b want 1", miso_oe); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL latency_busy: got %0b want 1", busy); end
    xfer_byte(8'hA5, 1'b0, 8, 1'b1, r);
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL msb_rx_count: got %0d want 1", rx_cnt - rx0); end
    tests++; if (rx_byte !== 8'hA5) begin fails++; $display("FAIL msb_rx_byte: got %h want a5", rx_byte); end
    tests++; if (r !== 8'h3C) begin fails++; $display("FAIL msb_miso: got %h want 3c", r); end
    tests++; if (ur_cnt - ur0 !== 0) begin fails++; $display("FAIL msb_underrun: got %0d want 0", ur_cnt - ur0); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL msb_frame_err: got %0d want 0", fe_cnt - fe0); end
    tests++; if ({busy, miso_oe, tx_ready} !== 3'b001) begin
      fails++; $display("FAIL msb_end_state: got %b want 001", {busy, miso_oe, tx_ready}); end
  endtask

  task automatic test_single_lsb();
    logic [7:0] r;
    int rx0 = rx_cnt;
    msb_lsb = 1'b1;
    load_tx(8'h80);
    @(negedge clk); cs = 1'b0;
    xfer_byte(8'h01, 1'b1, 8, 1'b1, r);
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL lsb_rx_count: got %0d want 1", rx_cnt - rx0); end
    tests++; if (rx_byte !== 8'h01) begin fails++; $display("FAIL lsb_rx_byte: got %h want 01", rx_byte); end
    tests++; if (r !== 8'h80) begin fails++; $display("FAIL lsb_miso: got %h want 80", r); end
    msb_lsb = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rx0 = rx_cnt, ur0 = ur_cnt, rr0 = rdy_rise;
    msb_lsb = 1'b0;
    load_tx(8'd0);
    fork
      begin
        for (int k = 1; k < 50; k++) load_tx(k[7:0]);
      end
      begin
        logic [7:0] r;
        @(negedge clk); cs = 1'b0;
        for (int b = 0; b < 50; b++) begin
          xfer_byte(8'(56 + b), 1'b0, 8, b == 49, r);
          tests++;
          if (r !== 8'(b)) begin fails++; $display("FAIL b2b_miso[%0d]: got %h want %h", b, r, 8'(b)); end
        end
      end
    join
    tests++; if (rx_cnt - rx0 !== 50) begin fails++; $display("FAIL b2b_rx_count: got %0d want 50", rx_cnt - rx0); end
    for (int k = 0; k < 50 && rx0 + k < rx_q.size(); k++) begin
      tests++;
      if (rx_q[rx0 + k] !== 8'(56 + k)) begin
        fails++; $display("FAIL b2b_rx[%0d]: got %h want %h", k, rx_q[rx0 + k], 8'(56 + k)); end
    end
    tests++; if (rdy_rise - rr0 !== 50) begin fails++; $display("FAIL b2b_ready_toggles: got %0d want 50", rdy_rise - rr0); end
    tests++; if (ur_cnt - ur0 !== 0) begin fails++; $display("FAIL b2b_underrun: got %0d want 0", ur_cnt - ur0); end
  endtask

  task automatic test_underrun();
    logic [7:0] r1, r2;
    int ur0 = ur_cnt;
    load_tx(8'h11);
    @(negedge clk); cs = 1'b0;
    xfer_byte(8'h22, 1'b0, 8, 1'b0, r1);
    xfer_byte(8'h33, 1'b0, 8, 1'b1, r2);
    tests++; if (r1 !== 8'h11) begin fails++; $display("FAIL ur_first: got %h want 11", r1); end
    tests++; if (r2 !== 8'h00) begin fails++; $display("FAIL ur_idle_byte: got %h want 00", r2); end
    tests++; if (ur_cnt - ur0 !== 1) begin fails++; $display("FAIL ur_count: got %0d want 1", ur_cnt - ur0); end
    tests++; if (rx_byte !== 8'h33) begin fails++; $display("FAIL ur_rx_byte: got %h want 33", rx_byte); end
  endtask

  task automatic test_frame_err();
    logic [7:0] r;
    int rx0 = rx_cnt, fe0 = fe_cnt;
    @(negedge clk); cs = 1'b0;
    xfer_byte(8'hFF, 1'b0, 5, 1'b1, r);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL fe_count: got %0d want 1", fe_cnt - fe0); end
    tests++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL fe_rx_count: got %0d want 0", rx_cnt - rx0); end
    tests++; if (rx_byte !== 8'h33) begin fails++; $display("FAIL fe_rx_hold: got %h want 33", rx_byte); end
    @(negedge clk); cs = 1'b0;
    xfer_byte(8'h7E, 1'b0, 8, 1'b1, r);
    tests++; if (rx_byte !== 8'h7E) begin fails++; $display("FAIL fe_next_byte: got %h want 7e", rx_byte); end
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL fe_next_count: got %0d want 1", rx_cnt - rx0); end
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL fe_no_extra: got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    int rx0, fe0;
    @(negedge clk); cs = 1'b0;
    xfer_byte(8'hAA, 1'b0, 3, 1'b0, r);
    arst = 1'b1;
    #2;
    tests++; if ({miso, miso_oe, busy, tx_ready} !== 4'b0001) begin
      fails++; $display("FAIL mid_rst_outputs: got %b want 0001", {miso, miso_oe, busy, tx_ready}); end
    tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL mid_rst_rx_byte: got %h want 00", rx_byte); end
    repeat (3) @(negedge clk);
    arst = 1'b0;
    rx0 = rx_cnt; fe0 = fe_cnt;
    xfer_byte(8'hFF, 1'b0, 5, 1'b0, r);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_idle_busy: got %0b want 0", busy); end
    cs = 1'b1;
    repeat (16) @(negedge clk);
    tests++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL mid_rst_no_rx: got %0d want 0", rx_cnt - rx0); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL mid_rst_no_fe: got %0d want 0", fe_cnt - fe0); end
    cs = 1'b0;
    xfer_byte(8'hC3, 1'b0, 8, 1'b1, r);
    tests++; if (rx_byte !== 8'hC3) begin fails++; $display("FAIL mid_rst_next_byte: got %h want c3", rx_byte); end
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL mid_rst_next_count: got %0d want 1", rx_cnt - rx0); end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_single_lsb();
    test_back_to_back();
    test_underrun();
    test_frame_err();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
